// File: rtl/sar_conv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sar_conv_ctrl: sequences sample / convert / capture for a SAR ADC core   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module sar_conv_ctrl #(
   parameter int N_BITS        = 8,
   parameter int SAMPLE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cont,
   output logic              sample,
   output logic              alg_rst,
   output logic              En,
   input  logic [N_BITS-1:0] d_in,
   output logic [N_BITS-1:0] data_out,
   output logic              valid,
   input  logic              ready,
   output logic              busy,
   output logic              overrun
);

   localparam int              c_BIT_W    = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam logic [3:0]      c_SMP_LAST = 4'(SAMPLE_CYCLES - 1);
   localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(N_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SAMPLE  = 2'd1,
      S_CONVERT = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   state_t               r_state;
   logic [3:0]           r_smp_cnt;
   logic [c_BIT_W-1:0]   r_bit_cnt;

   // Outputs are set on the edge that enters a state, so they are pure flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_smp_cnt <= '0;
         r_bit_cnt <= '0;
         sample    <= 1'b0;
         alg_rst   <= 1'b0;
         En        <= 1'b0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
         data_out  <= '0;
      end else begin
         if (valid && ready) begin
            valid <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (start || cont) begin
                  r_state   <= S_SAMPLE;
                  r_smp_cnt <= '0;
                  sample    <= 1'b1;
                  alg_rst   <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            S_SAMPLE: begin
               if (r_smp_cnt == c_SMP_LAST) begin
                  r_state   <= S_CONVERT;
                  r_bit_cnt <= '0;
                  sample    <= 1'b0;
                  alg_rst   <= 1'b0;
                  En        <= 1'b1;
               end else begin
                  r_smp_cnt <= r_smp_cnt + 4'd1;
               end
            end
            S_CONVERT: begin
               if (r_bit_cnt == c_BIT_LAST) begin
                  r_state <= S_CAPTURE;
                  En      <= 1'b0;
               end else begin
                  r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
               end
            end
            S_CAPTURE: begin
               // A capture always wins over a same-edge consume; only an
               // unread word being replaced sets the sticky flag.
               data_out <= d_in;
               valid    <= 1'b1;
               if (valid && !ready) begin
                  overrun <= 1'b1;
               end
               if (cont) begin
                  r_state   <= S_SAMPLE;
                  r_smp_cnt <= '0;
                  sample    <= 1'b1;
                  alg_rst   <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sar_conv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sar_conv_ctrl: directed scoreboard bench for sar_conv_ctrl            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_sar_conv_ctrl;

   localparam int SC = 2;
   localparam int N  = 8;

   logic       clk;
   logic       rst;
   logic       start, cont, ready;
   logic [7:0] d_in;
   logic       sample, alg_rst, En, valid, busy, overrun;
   logic [7:0] data_out;

   logic       start2;
   logic [3:0] d2;
   logic       sample2, alg2, en2, valid2, busy2, ovr2;
   logic [3:0] data2;

   int         checks;
   int         errors;
   logic [7:0] exp_q[$];

   sar_conv_ctrl #(.N_BITS(N), .SAMPLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .start(start), .cont(cont),
      .sample(sample), .alg_rst(alg_rst), .En(En),
      .d_in(d_in), .data_out(data_out), .valid(valid), .ready(ready),
      .busy(busy), .overrun(overrun)
   );

   sar_conv_ctrl #(.N_BITS(4), .SAMPLE_CYCLES(1)) dut_small (
      .clk(clk), .rst(rst), .start(start2), .cont(1'b0),
      .sample(sample2), .alg_rst(alg2), .En(en2),
      .d_in(d2), .data_out(data2), .valid(valid2), .ready(1'b1),
      .busy(busy2), .overrun(ovr2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [31:0] obs);
      logic [7:0] w;
      check({tag, " sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         w = exp_q.pop_front();
         check(tag, obs, 32'(w));
      end
   endtask

   // Caller raises start before the call; m counts edges after the start edge.
   task automatic run_wave(input int m_last, input int start_hold, input int repulse_m);
      logic [4:0] e;
      for (int m = 0; m <= m_last; m++) begin
         tick();
         start = ((m + 1) < start_hold) || (m == repulse_m);
         e = {1'(m < SC), 1'(m < SC), 1'(m >= SC && m < SC + N),
              1'(m <= SC + N), 1'(m == SC + N + 1)};
         check($sformatf("wave m=%0d {smp,arst,en,busy,vld}", m),
               32'({sample, alg_rst, En, busy, valid}), 32'(e));
         if (m == SC + N + 1) check_word("data_out", 32'(data_out));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start  = 1'b0;
      cont   = 1'b0;
      ready  = 1'b0;
      d_in   = 8'h00;
      start2 = 1'b0;
      d2     = 4'h0;

      // Reset state, before any clock edge
      #2;
      check("reset outputs", 32'({sample, alg_rst, En, busy, valid, overrun}), 32'd0);
      check("reset data_out", 32'(data_out), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Single conversion, consumer always ready
      ready = 1'b1;
      d_in  = 8'hA5;
      exp_q.push_back(8'hA5);
      start = 1'b1;
      run_wave(12, 1, -1);
      check("A5 held after consume", 32'(data_out), 32'hA5);

      // Long start plus re-pulse during CONVERT: one conversion only
      d_in = 8'h5C;
      exp_q.push_back(8'h5C);
      start = 1'b1;
      run_wave(20, 3, 5);

      // Continuous mode, no consumer: second capture overruns
      ready = 1'b0;
      cont  = 1'b1;
      d_in  = 8'h3C;
      exp_q.push_back(8'h3C);
      tick();
      repeat (11) tick();
      check_word("cont first word", 32'(data_out));
      check("cont first valid/ovr/busy", 32'({valid, overrun, busy}), 32'b101);
      d_in = 8'hC3;
      exp_q.push_back(8'hC3);
      cont = 1'b0;
      repeat (11) tick();
      check_word("overrun second word", 32'(data_out));
      check("overrun valid/ovr/busy", 32'({valid, overrun, busy}), 32'b110);
      ready = 1'b1;
      tick();
      check("after consume valid/ovr", 32'({valid, overrun}), 32'b01);
      tick();
      check("overrun sticky, data held", 32'({overrun, data_out}), 32'({1'b1, 8'hC3}));

      // Only reset clears overrun
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("overrun cleared by reset", 32'(overrun), 32'd0);
      tick();

      // Continuous mode, consumer ready exactly at the second capture
      ready = 1'b0;
      cont  = 1'b1;
      d_in  = 8'h5A;
      exp_q.push_back(8'h5A);
      tick();
      repeat (11) tick();
      check_word("simul first word", 32'(data_out));
      d_in = 8'h96;
      exp_q.push_back(8'h96);
      cont = 1'b0;
      repeat (10) tick();
      ready = 1'b1;
      tick();
      check_word("simul second word", 32'(data_out));
      check("simul valid/ovr", 32'({valid, overrun}), 32'b10);
      tick();
      check("simul drained valid/busy", 32'({valid, busy}), 32'b00);

      // Asynchronous reset during the 5th En cycle aborts the conversion
      d_in  = 8'h77;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      check("En before abort", 32'({En, busy}), 32'b11);
      #2 rst = 1'b1;
      #1;
      check("async reset outputs", 32'({sample, alg_rst, En, busy, valid, overrun}), 32'd0);
      check("async reset data_out", 32'(data_out), 32'd0);
      #2 rst = 1'b0;
      repeat (15) tick();
      check("post-abort idle, no capture", 32'({busy, valid, data_out}), 32'd0);
      d_in = 8'hE7;
      exp_q.push_back(8'hE7);
      start = 1'b1;
      run_wave(12, 1, -1);

      // Small build: SAMPLE_CYCLES=1, N_BITS=4
      d2     = 4'h9;
      exp_q.push_back(8'h09);
      start2 = 1'b1;
      for (int m = 0; m <= 7; m++) begin
         tick();
         start2 = 1'b0;
         check($sformatf("small m=%0d {smp,en,vld}", m), 32'({sample2, en2, valid2}),
               32'({1'(m < 1), 1'(m >= 1 && m < 5), 1'(m == 6)}));
         if (m == 6) check_word("small data_out", 32'(data2));
      end

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
